// File: rtl/uart_rx_pkg.sv
// Shared types and limits for the UART receive deserialiser.
// Optional parity support in the blocks that import this is selected by PARITY_CHECK_EN.
package uart_rx_pkg;

  localparam int DATA_WIDTH_MIN     = 5;
  localparam int DATA_WIDTH_MAX     = 16;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_bit_counter.sv
// Counts accepted payload bits and maps the count to a shift-register index
// for LSB-first or MSB-first reception.
module uart_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter bit  MSB_FIRST  = 1'b0,
  localparam int CW         = $clog2(DATA_WIDTH + 1),
  localparam int IW         = $clog2(DATA_WIDTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          advance,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [CW-1:0] cnt;
  logic [IW-1:0] cnt_low;

  // NOTE: flops use <= so every register samples the values from before the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (advance) cnt <= cnt + CW'(1);
  end

  assign cnt_low = cnt[IW-1:0];
  assign idx     = MSB_FIRST ? (IW'(DATA_WIDTH - 1) - cnt_low) : cnt_low;
  assign last    = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_rx_deser_p.sv
// Strobe-driven serial-to-parallel receiver with a one-word output buffer.
// Define PARITY_CHECK_EN to add the parity stage and par_err reporting.
module uart_rx_deser_p
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_frame,
  input  logic                  sample_strobe,
  input  logic                  sampled_bit,
  input  logic                  deser_enable,
  input  logic                  par_odd,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  out_valid,
  output logic                  par_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int IW = $clog2(DATA_WIDTH);

  rx_state_t             state, state_next;
  logic                  strobe_en;
  logic                  cnt_clear, bit_take, commit;
  logic [IW-1:0]         idx;
  logic                  last;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_calc;

  assign strobe_en = sample_strobe & deser_enable;

  uart_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_bit_counter (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (cnt_clear),
    .advance (bit_take),
    .idx     (idx),
    .last    (last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:  if (start_frame) state_next = SHIFT;
      SHIFT: begin
        if (start_frame) state_next = SHIFT;
        else if (strobe_en && last)
`ifdef PARITY_CHECK_EN
          state_next = PARITY;
`else
          state_next = COMMIT;
`endif
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (start_frame)    state_next = SHIFT;
        else if (strobe_en) state_next = COMMIT;
      end
`endif
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef PARITY_CHECK_EN
  logic par_take;
`endif

  always_comb begin
    busy      = 1'b0;
    cnt_clear = 1'b0;
    bit_take  = 1'b0;
    commit    = 1'b0;
`ifdef PARITY_CHECK_EN
    par_take  = 1'b0;
`endif
    case (state)
      IDLE:  cnt_clear = start_frame;
      SHIFT: begin
        busy      = 1'b1;
        cnt_clear = start_frame;
        bit_take  = strobe_en & ~start_frame;
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        busy      = 1'b1;
        cnt_clear = start_frame;
        par_take  = strobe_en & ~start_frame;
      end
`endif
      COMMIT: begin
        busy   = 1'b1;
        commit = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // NOTE: the shift register is cleared by reset as well as by each new frame,
  // so no stale bits from an aborted frame can surface in P_DATA.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           shift_q      <= '0;
    else if (cnt_clear) shift_q      <= '0;
    else if (bit_take)  shift_q[idx] <= sampled_bit;
  end

`ifdef PARITY_CHECK_EN
  logic par_bit_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           par_bit_q <= 1'b0;
    else if (cnt_clear) par_bit_q <= 1'b0;
    else if (par_take)  par_bit_q <= sampled_bit;
  end

  assign par_calc = ^shift_q ^ par_bit_q ^ par_odd;
`else
  logic unused_par_odd;
  assign unused_par_odd = par_odd;
  assign par_calc       = 1'b0;
`endif

  // A held word wins over a new one unless it is being accepted this cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA    <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!out_valid || out_ready) begin
          P_DATA    <= shift_q;
          par_err   <= par_calc;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser_p.sv
// Bench for uart_rx_deser_p: LSB-first and MSB-first instances share stimulus and
// are compared every cycle against a frame-level queue model.
module tb_uart_rx_deser_p;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic         CLK, RST;
  logic         start_frame, sample_strobe, sampled_bit, deser_enable, par_odd, out_ready;
  logic [W-1:0] p_data_l, p_data_m;
  logic         out_valid_l, out_valid_m, par_err_l, par_err_m;
  logic         overrun_l, overrun_m, busy_l, busy_m;

  uart_rx_deser_p #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RST(RST), .start_frame(start_frame), .sample_strobe(sample_strobe),
    .sampled_bit(sampled_bit), .deser_enable(deser_enable), .par_odd(par_odd),
    .out_ready(out_ready), .P_DATA(p_data_l), .out_valid(out_valid_l),
    .par_err(par_err_l), .overrun(overrun_l), .busy(busy_l));

  uart_rx_deser_p #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(CLK), .RST(RST), .start_frame(start_frame), .sample_strobe(sample_strobe),
    .sampled_bit(sampled_bit), .deser_enable(deser_enable), .par_odd(par_odd),
    .out_ready(out_ready), .P_DATA(p_data_m), .out_valid(out_valid_m),
    .par_err(par_err_m), .overrun(overrun_m), .busy(busy_m));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: received bits queue up; a completed frame commits one cycle later.
  logic     m_bits[$];
  bit       m_armed, m_commit, m_valid, m_perr, m_ovr;
  logic     m_par;
  logic [W-1:0] m_data_l, m_data_m;

  function automatic logic [W-1:0] pack_bits(input bit msb);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) w[msb ? W-1-i : i] = m_bits[i];
    return w;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_bits.delete();
      m_armed = 0; m_commit = 0; m_valid = 0; m_perr = 0; m_ovr = 0; m_par = 0;
      m_data_l = '0; m_data_m = '0;
    end else begin
      m_ovr = 0;
      if (m_commit) begin
        m_commit = 0;
        if (!m_valid || out_ready) begin
          m_data_l = pack_bits(1'b0);
          m_data_m = pack_bits(1'b1);
          m_perr   = HAS_PAR ? (^m_data_l ^ m_par ^ par_odd) : 1'b0;
          m_valid  = 1;
        end else begin
          m_ovr = 1;
        end
      end else begin
        if (m_valid && out_ready) m_valid = 0;
        if (start_frame) begin
          m_bits.delete();
          m_armed = 1;
        end else if (m_armed && sample_strobe && deser_enable) begin
          if (m_bits.size() < W) m_bits.push_back(sampled_bit);
          else begin
            m_par = sampled_bit; m_armed = 0; m_commit = 1;
          end
          if (!HAS_PAR && m_bits.size() == W) begin
            m_armed = 0; m_commit = 1;
          end
        end
      end
    end
  end

  int commits = 0, ovr_seen = 0;
  bit prev_valid = 0;

  always @(negedge CLK) begin
    if (RST) begin
      check("p_data_lsb",  p_data_l,    m_data_l);
      check("p_data_msb",  p_data_m,    m_data_m);
      check("valid_lsb",   out_valid_l, m_valid);
      check("valid_msb",   out_valid_m, m_valid);
      check("par_err_lsb", par_err_l,   m_perr);
      check("par_err_msb", par_err_m,   m_perr);
      check("overrun_lsb", overrun_l,   m_ovr);
      check("overrun_msb", overrun_m,   m_ovr);
      check("busy_lsb",    busy_l,      m_armed || m_commit);
      check("busy_msb",    busy_m,      m_armed || m_commit);
      if (out_valid_l && !prev_valid) commits++;
      if (overrun_l) ovr_seen++;
    end
    prev_valid = out_valid_l;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Bit i of v is the i-th bit on the line; returns just after the final strobe's edge.
  task automatic send_frame(input logic [15:0] v, input logic pbit, input bit noise, input bit do_start);
    if (do_start) begin
      start_frame = 1'b1; tick(); start_frame = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      if (noise && (i % 3 == 1)) begin
        sample_strobe = 1'b1; deser_enable = 1'b0; sampled_bit = ~v[i];
        tick();
        deser_enable = 1'b1;
      end
      sample_strobe = 1'b1; sampled_bit = v[i];
      tick();
      sample_strobe = 1'b0;
      if (noise && i < W-1) tick();
    end
    if (HAS_PAR) begin
      sample_strobe = 1'b1; sampled_bit = pbit;
      tick();
      sample_strobe = 1'b0;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pdata_l"}, p_data_l, 0);
    check({tag, "_pdata_m"}, p_data_m, 0);
    check({tag, "_valid"},   {out_valid_l, out_valid_m}, 0);
    check({tag, "_perr"},    {par_err_l, par_err_m}, 0);
    check({tag, "_ovr"},     {overrun_l, overrun_m}, 0);
    check({tag, "_busy"},    {busy_l, busy_m}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int base_commits, base_ovr;

  initial begin
    RST = 1'b1; start_frame = 0; sample_strobe = 0; sampled_bit = 0;
    deser_enable = 1'b1; par_odd = 1'b0; out_ready = 1'b0;
    #2 RST = 1'b0;
    #1 check_all_zero("reset");
    tick(); tick();
    RST = 1'b1;
    tick();

    // Strobe in IDLE is ignored, then 0xA5 LSB-first with 2-cycle latency.
    sample_strobe = 1'b1; sampled_bit = 1'b1; tick(); sample_strobe = 1'b0;
    send_frame(16'h00A5, 1'b0, 1'b0, 1'b1);
    check("a5_lat_early", out_valid_l, 0);
    tick();
    check("a5_lat_valid", out_valid_l, 1);
    check("a5_lsb", p_data_l, 8'hA5);
    check("a5_msb", p_data_m, 8'hA5);
    check("a5_par0", par_err_l, 0);
    accept();
    check("a5_accepted", out_valid_l, 0);

    // Same word with parity bit 1 under even parity.
    send_frame(16'h00A5, 1'b1, 1'b0, 1'b1);
    tick();
    check("a5_par1", par_err_l, HAS_PAR ? 1 : 0);
    accept();

    // Disabled strobes and gaps; odd parity with a correct parity bit.
    par_odd = 1'b1;
    send_frame(16'h000B, 1'b0, 1'b1, 1'b1);
    tick();
    check("0b_lsb", p_data_l, 8'h0B);
    check("0b_msb", p_data_m, 8'hD0);
    check("0b_par_odd", par_err_l, 0);
    accept();
    par_odd = 1'b0;

    // Overrun: 0x3C held, 0x81 completes and is dropped.
    send_frame(16'h003C, 1'b0, 1'b0, 1'b1);
    tick();
    send_frame(16'h0081, 1'b0, 1'b0, 1'b1);
    check("ovr_before", overrun_l, 0);
    tick();
    check("ovr_pulse", overrun_l, 1);
    check("ovr_keep", p_data_l, 8'h3C);
    check("ovr_valid", out_valid_l, 1);
    tick();
    check("ovr_end", overrun_l, 0);
    check("ovr_keep2", p_data_l, 8'h3C);

    // Commit coincides with accept of the held word: load, stay valid.
    send_frame(16'h0096, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("sim_valid", out_valid_l, 1);
    check("sim_lsb", p_data_l, 8'h96);
    check("sim_msb", p_data_m, 8'h69);
    check("sim_no_ovr", overrun_l, 0);
    accept();

    // Abort after 4 strobes; restart cycle carries a strobe that must be ignored.
    base_commits = commits; base_ovr = ovr_seen;
    start_frame = 1'b1; tick(); start_frame = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_strobe = 1'b1; sampled_bit = 1'b0; tick();
    end
    start_frame = 1'b1; sample_strobe = 1'b1; sampled_bit = 1'b0; tick();
    start_frame = 1'b0; sample_strobe = 1'b0;
    send_frame(16'h00FF, 1'b0, 1'b0, 1'b0);
    tick();
    check("abort_lsb", p_data_l, 8'hFF);
    check("abort_msb", p_data_m, 8'hFF);
    repeat (3) tick();
    check("abort_commits", commits - base_commits, 1);
    check("abort_no_ovr", ovr_seen - base_ovr, 0);

    // Reset mid-SHIFT with 0xFF still pending, then a clean 0x55 frame.
    start_frame = 1'b1; tick(); start_frame = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_strobe = 1'b1; sampled_bit = 1'b1; tick();
    end
    sample_strobe = 1'b0;
    #2 RST = 1'b0;
    #1 check_all_zero("midrst");
    tick();
    RST = 1'b1;
    tick();
    send_frame(16'h0055, 1'b0, 1'b0, 1'b1);
    tick();
    check("r55_valid", out_valid_l, 1);
    check("r55_lsb", p_data_l, 8'h55);
    check("r55_msb", p_data_m, 8'hAA);
    accept();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser_p.md
UART_RX_DESER_P -- requirements
Module: uart_rx_deser_p

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame (legal range 5..16).
REQ-002 SHALL have parameter MSB_FIRST, default 0, meaning bit order: 0 = LSB received first, 1 = MSB received first.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_frame  input  1  one-cycle pulse that arms capture of a new frame.
REQ-006 SHALL have port sample_strobe  input  1  one-cycle pulse that marks sampled_bit as valid.
REQ-007 SHALL have port sampled_bit  input  1  serial bit value.
REQ-008 SHALL have port deser_enable  input  1  when low, strobes are ignored and capture pauses.
REQ-009 SHALL have port par_odd  input  1  parity sense: 0 = even, 1 = odd; used only when PARITY_CHECK_EN is defined.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port P_DATA  output  DATA_WIDTH  parallel word.
REQ-012 SHALL have port out_valid  output  1  P_DATA holds an unconsumed word.
REQ-013 SHALL have port par_err  output  1  parity mismatch for the word currently in P_DATA.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, SHIFT, PARITY and COMMIT.
REQ-017 SHALL move IDLE->SHIFT on start_frame, clearing the shift register and the bit counter to 0.
REQ-018 SHALL, in SHIFT, on each strobe with deser_enable high, store sampled_bit at index cnt (LSB-first) or DATA_WIDTH-1-cnt (MSB-first), then increment cnt.
REQ-019 SHALL, on the strobe where cnt = DATA_WIDTH-1, go to PARITY when PARITY_CHECK_EN is defined and to COMMIT otherwise.
REQ-020 SHALL, in PARITY, capture the parity bit on the next enabled strobe and then go to COMMIT.
REQ-021 SHALL, in COMMIT (exactly one cycle), load P_DATA and par_err from the shift register, set out_valid, and return to IDLE.
REQ-022 SHALL give a latency of 2 cycles: out_valid is high 2 cycles after the cycle of the final strobe.
REQ-023 SHALL double-buffer: the shift register may fill a new frame while out_valid is held.
REQ-024 SHALL clear out_valid on the edge where out_valid and out_ready are both high; P_DATA is stable while out_valid is high.
REQ-025 SHALL handle COMMIT with out_valid high and out_ready low as follows: keep the old P_DATA and par_err, discard the new word, and pulse overrun for 1 cycle.
REQ-026 SHALL treat COMMIT with a simultaneous accept as a successful load with no overrun, leaving out_valid high.
REQ-027 SHALL treat start_frame in SHIFT or PARITY as an abort-and-restart: return to SHIFT with cnt 0 and no commit; start_frame takes priority over a strobe in the same cycle.
REQ-028 SHALL ignore strobes in IDLE and COMMIT, and ignore start_frame in COMMIT.
REQ-029 SHALL compute parity as the XOR of the data bits, the parity bit and par_odd; par_err = 1 on a nonzero result.

Reset
REQ-030 SHALL, on RST low, immediately force state IDLE, cnt 0, shift register 0, P_DATA 0, out_valid 0, par_err 0, overrun 0 and busy 0.
REQ-031 SHALL discard any partially captured frame or pending word when reset occurs mid-operation.

Configuration
REQ-032 SHALL, when PARITY_CHECK_EN is defined, include the PARITY state, the parity register and the par_err logic.
REQ-033 SHALL, when PARITY_CHECK_EN is not defined, omit PARITY and tie par_err to 0; par_odd is unused.

Structure
REQ-034 SHALL place the state enum typedef, the DATA_WIDTH limits and the default width constant in shared package uart_rx_pkg.
REQ-035 SHALL place the bit counter and index mapping in sub-module uart_bit_counter, parametrised by DATA_WIDTH and MSB_FIRST.

Verification
REQ-036 SHALL cover: DATA_WIDTH 8, LSB-first, bits 1,0,1,0,0,1,0,1 -> P_DATA 0xA5, out_valid high 2 cycles after the last strobe.
REQ-037 SHALL cover: MSB_FIRST 1, same bit sequence -> P_DATA 0xA5 reversed, i.e. 0xA5 read MSB-first equals 0xA5.
REQ-038 SHALL cover: PARITY_CHECK_EN defined, even parity, 0xA5 with parity bit 0 -> par_err 0; with parity bit 1 -> par_err 1.
REQ-039 SHALL cover: 0x3C pending with out_ready low, then frame 0x81 completes -> P_DATA stays 0x3C and overrun pulses for 1 cycle.
REQ-040 SHALL cover: start_frame after 4 strobes, then 8 bits of 0xFF -> P_DATA 0xFF with exactly one commit.
REQ-041 SHALL cover: RST low during SHIFT -> all outputs 0 immediately; a subsequent full frame of 0x55 captures correctly.
